fetch_stage: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register for the 5-stage RV32I core. It owns the PC and issues requests on a single-outstanding instruction-memory handshake. It obeys the hazard unit's `StallF`, `StallD`, `FlushD` and `PCSrcE`, and presents `InstrD`, `PCD`, `PCPlus4D` and `ValidD` to decode. A one-entry hold buffer absorbs a response that returns while decode is stalled, and an explicit kill state discards wrong-path responses after a redirect.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory handshake between the fetch stage (master) and the
// instruction memory (slave). Single outstanding request.
//   ImemReq    master -> slave  request valid
//   ImemAddr   master -> slave  request address (word aligned in practice)
//   ImemReady  slave  -> master request accepted when high with ImemReq
//   ImemRValid slave  -> master response valid, >= 1 cycle after acceptance
//   ImemRData  slave  -> master response instruction word
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq, ImemAddr,
        input  ImemReady, ImemRValid, ImemRData
    );

    modport slave (
        input  ImemReq, ImemAddr,
        output ImemReady, ImemRValid, ImemRData
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// RV32I instruction-fetch stage plus the IF/ID pipeline register. Owns the
// PC, issues one request at a time on the imem handshake, parks a response
// in a one-entry hold buffer while decode is stalled, and throws away the
// in-flight response after a redirect (KILL state).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   StallF, StallD      hazard-unit stalls for fetch / decode
//   FlushD              turn IF/ID into a bubble
//   PCSrcE, PCTargetE   taken branch/jump redirect from EX
//   imem                instruction-memory handshake (master side)
//   PCF                 current fetch PC (also drives imem.ImemAddr)
//   InstrD, PCD,
//   PCPlus4D, ValidD    IF/ID register contents presented to decode
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc4_d;
    logic        r_valid_d;

    logic        w_req;
    logic        w_deliver;   // a word goes into IF/ID this cycle
    logic        w_capture;   // response parked in the hold buffer
    logic [31:0] w_word;
    logic [31:0] w_pc_plus4;

    // A redirect in ISSUE suppresses the request so the old PC never leaves.
    assign w_req      = (r_state == S_ISSUE) & ~StallF & ~PCSrcE & ~reset;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem.ImemReq  = w_req;
    assign imem.ImemAddr = r_pc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_ISSUE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deliver   = 1'b0;
        w_capture   = 1'b0;
        w_word      = r_hold;
        case (r_state)
            S_ISSUE: begin
                if (w_req && imem.ImemReady) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_word = imem.ImemRData;
                if (PCSrcE) begin
                    // Response already here: drop it. Otherwise wait it out.
                    w_state_nxt = imem.ImemRValid ? S_ISSUE : S_KILL;
                end else if (imem.ImemRValid) begin
                    if (StallD) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_FULL;
                    end else begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_FULL: begin
                if (PCSrcE) begin
                    w_state_nxt = S_ISSUE;
                end else if (!StallD) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_KILL: begin
                if (imem.ImemRValid) w_state_nxt = S_ISSUE;
            end
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    // PC advances only when its word reaches IF/ID; redirect wins.
    always_ff @(posedge clk) begin
        if (reset)          r_pc <= RESET_PC;
        else if (PCSrcE)    r_pc <= PCTargetE;
        else if (w_deliver) r_pc <= w_pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (reset)          r_hold <= 32'd0;
        else if (w_capture) r_hold <= imem.ImemRData;
    end

    // IF/ID: reset > flush > stall(hold) > deliver > bubble.
    // A bubble keeps PCD/PCPlus4D so only InstrD/ValidD change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= 32'd0;
            r_pc4_d   <= 32'd0;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_deliver) begin
                r_instr_d <= w_word;
                r_pc_d    <= r_pc;
                r_pc4_d   <= w_pc_plus4;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign PCF      = r_pc;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Drives fetch_stage through directed scenarios and a randomized run. The
// instruction memory is a bench model: words are a fixed function of the
// address, at most one request is tracked, latency and ready are settable.
// Expected IF/ID contents come from the architectural fetch sequence
// (PC starts at reset value, +4 per delivered word, redirect reloads it).
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallf, stalld, flushd, pcsrce;
    logic [31:0] target;
    logic [31:0] pcf, instrd, pcd, pc4d;
    logic        validd;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk      (clk),
        .reset    (rst),
        .StallF   (stallf),
        .StallD   (stalld),
        .FlushD   (flushd),
        .PCSrcE   (pcsrce),
        .PCTargetE(target),
        .imem     (bus),
        .PCF      (pcf),
        .InstrD   (instrd),
        .PCD      (pcd),
        .PCPlus4D (pc4d),
        .ValidD   (validd)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // memory model state
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_cnt  = 0;
    int          rdy_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          last_req, last_rv, last_rdy;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'h9BDF};
    endfunction

    task automatic haz(input bit sf, input bit sd, input bit fd, input bit pc,
                       input logic [31:0] t);
        stallf = sf; stalld = sd; flushd = fd; pcsrce = pc; target = t;
    endtask

    // One clock cycle: memory drives its outputs, comb outputs are sampled,
    // the edge happens, then the memory model books the handshake.
    task automatic cyc();
        bus.ImemRValid = mem_pend && (mem_cnt == 0);
        bus.ImemRData  = bus.ImemRValid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        last_rdy       = ($urandom_range(99) < rdy_pct);
        bus.ImemReady  = last_rdy;
        #1;
        last_req  = bus.ImemReq;
        last_addr = bus.ImemAddr;
        last_rv   = bus.ImemRValid;
        if (last_req) begin
            nchk++;
            if (mem_pend) begin
                nerr++; $display("FAIL single_outstanding: request at %h while one is pending", last_addr);
            end
        end
        @(posedge clk); #1;
        if (rst) mem_pend = 1'b0;
        else begin
            if (last_rv) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (last_req && last_rdy) begin
                mem_pend = 1'b1;
                mem_addr = last_addr;
                mem_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; haz(0, 0, 0, 0, 32'd0);
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (2) begin
            cyc();
            nchk++; if (last_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", last_req); end
        end
        nchk++; if (pcf !== RST_PC) begin nerr++; $display("FAIL reset_pcf: got %h want %h", pcf, RST_PC); end
        nchk++; if ({validd, instrd, pcd, pc4d} !== {1'b0, NOP, 32'd0, 32'd0}) begin
            nerr++; $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h want 0/%h/0/0", validd, instrd, pcd, pc4d, NOP);
        end
        rst = 1'b0;
    endtask

    task automatic test_straight();
        logic [31:0] p;
        for (int c = 0; c < 6; c++) begin
            p = 32'd4 * 32'(c / 2);
            cyc();
            nchk++; if (last_req !== (c % 2 == 0)) begin nerr++; $display("FAIL straight_req c%0d: got %b", c, last_req); end
            if (c % 2 == 0) begin
                nchk++; if (last_addr !== p) begin nerr++; $display("FAIL straight_addr c%0d: got %h want %h", c, last_addr, p); end
                nchk++; if ({validd, instrd} !== {1'b0, NOP}) begin nerr++; $display("FAIL straight_bubble c%0d: got v=%b i=%h", c, validd, instrd); end
            end else begin
                nchk++; if ({validd, instrd, pcd, pc4d} !== {1'b1, mem_word(p), p, p + 32'd4}) begin
                    nerr++; $display("FAIL straight_deliver c%0d: got v=%b i=%h pc=%h pc4=%h want pc=%h", c, validd, instrd, pcd, pc4d, p);
                end
            end
        end
    endtask

    task automatic test_hold();
        haz(0, 0, 0, 0, 32'd0);
        cyc();
        nchk++; if (!(last_req && last_addr == 32'd12)) begin nerr++; $display("FAIL hold_req: got req=%b addr=%h want 1/0000000c", last_req, last_addr); end
        stalld = 1'b1;
        repeat (3) begin
            cyc();
            nchk++; if (last_req !== 1'b0) begin nerr++; $display("FAIL hold_noreq: got %b want 0", last_req); end
            nchk++; if ({validd, instrd, pcd, pc4d, pcf} !== {1'b0, NOP, 32'd8, 32'd12, 32'd12}) begin
                nerr++; $display("FAIL hold_ifid: got v=%b i=%h pc=%h pc4=%h pcf=%h", validd, instrd, pcd, pc4d, pcf);
            end
        end
        stalld = 1'b0;
        cyc();
        nchk++; if ({validd, instrd, pcd, pc4d, pcf} !== {1'b1, mem_word(32'd12), 32'd12, 32'd16, 32'd16}) begin
            nerr++; $display("FAIL hold_release: got v=%b i=%h pc=%h pc4=%h pcf=%h", validd, instrd, pcd, pc4d, pcf);
        end
        cyc();
        nchk++; if (!(last_req && last_addr == 32'd16)) begin nerr++; $display("FAIL hold_next_req: got req=%b addr=%h want 1/00000010", last_req, last_addr); end
        cyc();
        nchk++; if ({validd, instrd, pcd} !== {1'b1, mem_word(32'd16), 32'd16}) begin
            nerr++; $display("FAIL hold_next_deliver: got v=%b i=%h pc=%h", validd, instrd, pcd);
        end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        cyc();
        nchk++; if (!(last_req && last_addr == 32'd20)) begin nerr++; $display("FAIL rw_req: got req=%b addr=%h want 1/00000014", last_req, last_addr); end
        haz(0, 0, 1, 1, 32'h100);
        cyc();
        nchk++; if ({last_req, pcf, validd} !== {1'b0, 32'h100, 1'b0}) begin nerr++; $display("FAIL rw_redirect: got req=%b pcf=%h v=%b", last_req, pcf, validd); end
        haz(0, 0, 0, 0, 32'd0);
        cyc();
        nchk++; if (last_req !== 1'b0) begin nerr++; $display("FAIL rw_kill_noreq: got %b want 0", last_req); end
        lat_min = 1; lat_max = 1;
        cyc();  // stale response returns here
        nchk++; if ({last_req, validd, instrd, pcd} !== {1'b0, 1'b0, NOP, 32'd16}) begin
            nerr++; $display("FAIL rw_discard: got req=%b v=%b i=%h pc=%h", last_req, validd, instrd, pcd);
        end
        cyc();
        nchk++; if (!(last_req && last_addr == 32'h100)) begin nerr++; $display("FAIL rw_target_req: got req=%b addr=%h want 1/00000100", last_req, last_addr); end
        cyc();
        nchk++; if ({validd, instrd, pcd, pc4d} !== {1'b1, mem_word(32'h100), 32'h100, 32'h104}) begin
            nerr++; $display("FAIL rw_target_deliver: got v=%b i=%h pc=%h pc4=%h", validd, instrd, pcd, pc4d);
        end
    endtask

    task automatic test_redirect_coincident();
        cyc();
        nchk++; if (!(last_req && last_addr == 32'h104)) begin nerr++; $display("FAIL rc_req: got req=%b addr=%h want 1/00000104", last_req, last_addr); end
        haz(0, 0, 1, 1, 32'h200);
        cyc();  // response and redirect together
        nchk++; if ({last_req, validd, instrd, pcf} !== {1'b0, 1'b0, NOP, 32'h200}) begin
            nerr++; $display("FAIL rc_discard: got req=%b v=%b i=%h pcf=%h", last_req, validd, instrd, pcf);
        end
        haz(0, 0, 0, 0, 32'd0);
        cyc();
        nchk++; if (!(last_req && last_addr == 32'h200)) begin nerr++; $display("FAIL rc_target_req: got req=%b addr=%h want 1/00000200", last_req, last_addr); end
        cyc();
        nchk++; if ({validd, instrd, pcd} !== {1'b1, mem_word(32'h200), 32'h200}) begin
            nerr++; $display("FAIL rc_target_deliver: got v=%b i=%h pc=%h", validd, instrd, pcd);
        end
    endtask

    task automatic test_full_redirect();
        cyc();  // request at 0x204
        haz(0, 1, 0, 0, 32'd0);
        cyc();  // response parked in hold buffer
        haz(0, 1, 1, 1, 32'h300);
        cyc();
        nchk++; if ({last_req, validd, pcf} !== {1'b0, 1'b0, 32'h300}) begin nerr++; $display("FAIL fr_redirect: got req=%b v=%b pcf=%h", last_req, validd, pcf); end
        haz(0, 0, 0, 0, 32'd0);
        cyc();
        nchk++; if (!(last_req && last_addr == 32'h300)) begin nerr++; $display("FAIL fr_target_req: got req=%b addr=%h want 1/00000300", last_req, last_addr); end
        nchk++; if (validd !== 1'b0) begin nerr++; $display("FAIL fr_buffer_dropped: got v=%b want 0", validd); end
        cyc();
        nchk++; if ({validd, instrd, pcd} !== {1'b1, mem_word(32'h300), 32'h300}) begin
            nerr++; $display("FAIL fr_target_deliver: got v=%b i=%h pc=%h", validd, instrd, pcd);
        end
    endtask

    task automatic test_wrap();
        haz(0, 0, 1, 1, 32'hFFFF_FFFC);
        rdy_pct = 0;
        cyc();
        nchk++; if ({last_req, pcf} !== {1'b0, 32'hFFFF_FFFC}) begin nerr++; $display("FAIL wrap_redirect: got req=%b pcf=%h", last_req, pcf); end
        haz(0, 0, 0, 0, 32'd0);
        repeat (4) begin
            cyc();
            nchk++; if ({last_req, last_addr, pcf} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
                nerr++; $display("FAIL wrap_backpressure: got req=%b addr=%h pcf=%h", last_req, last_addr, pcf);
            end
        end
        rdy_pct = 100;
        cyc();
        cyc();
        nchk++; if ({validd, instrd, pcd, pc4d, pcf} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'd0, 32'd0}) begin
            nerr++; $display("FAIL wrap_deliver: got v=%b i=%h pc=%h pc4=%h pcf=%h", validd, instrd, pcd, pc4d, pcf);
        end
        cyc();  // fetch 0
        cyc();  // deliver 0, PCF now 4
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3;
        cyc();
        nchk++; if (!(last_req && last_addr == 32'd4)) begin nerr++; $display("FAIL rm_req: got req=%b addr=%h want 1/00000004", last_req, last_addr); end
        rst = 1'b1;
        cyc();
        nchk++; if (last_req !== 1'b0) begin nerr++; $display("FAIL rm_reset_req: got %b want 0", last_req); end
        nchk++; if ({pcf, validd, instrd, pcd, pc4d} !== {RST_PC, 1'b0, NOP, 32'd0, 32'd0}) begin
            nerr++; $display("FAIL rm_reset_vals: got pcf=%h v=%b i=%h pc=%h pc4=%h", pcf, validd, instrd, pcd, pc4d);
        end
        rst = 1'b0; lat_min = 1; lat_max = 1;
        cyc();
        nchk++; if (!(last_req && last_addr == RST_PC)) begin nerr++; $display("FAIL rm_restart_req: got req=%b addr=%h", last_req, last_addr); end
        cyc();
        nchk++; if ({validd, instrd, pcd} !== {1'b1, mem_word(RST_PC), RST_PC}) begin
            nerr++; $display("FAIL rm_restart_deliver: got v=%b i=%h pc=%h", validd, instrd, pcd);
        end
    endtask

    task automatic test_random();
        logic [31:0] req_pc, del_pc;
        logic [96:0] prev;
        int          ndel;
        rst = 1'b1; haz(0, 0, 0, 0, 32'd0);
        cyc();
        rst = 1'b0;
        rdy_pct = 60; lat_min = 1; lat_max = 3;
        req_pc = RST_PC; del_pc = RST_PC; ndel = 0;
        for (int i = 0; i < 400; i++) begin
            haz($urandom_range(99) < 20, $urandom_range(99) < 30, 0, 0, 32'd0);
            prev = {validd, instrd, pcd, pc4d};
            cyc();
            if (stallf) begin
                nchk++; if (last_req !== 1'b0) begin nerr++; $display("FAIL rnd_stallf %0d: request while StallF", i); end
            end
            if (last_req && last_rdy) begin
                nchk++; if (last_addr !== req_pc) begin nerr++; $display("FAIL rnd_addr %0d: got %h want %h", i, last_addr, req_pc); end
                req_pc = req_pc + 32'd4;
            end
            nchk++;
            if (stalld) begin
                if ({validd, instrd, pcd, pc4d} !== prev) begin nerr++; $display("FAIL rnd_hold %0d: IF/ID changed under StallD", i); end
            end else if (validd) begin
                if ({instrd, pcd, pc4d} !== {mem_word(del_pc), del_pc, del_pc + 32'd4}) begin
                    nerr++; $display("FAIL rnd_deliver %0d: got i=%h pc=%h pc4=%h want pc=%h", i, instrd, pcd, pc4d, del_pc);
                end
                del_pc = del_pc + 32'd4;
                ndel++;
            end else if (instrd !== NOP) begin
                nerr++; $display("FAIL rnd_bubble %0d: got i=%h want %h", i, instrd, NOP);
            end
        end
        nchk++; if (ndel < 30) begin nerr++; $display("FAIL rnd_progress: got %0d deliveries want >= 30", ndel); end
    endtask

    initial begin
        rst = 1'b1;
        haz(0, 0, 0, 0, 32'd0);
        bus.ImemReady  = 1'b0;
        bus.ImemRValid = 1'b0;
        bus.ImemRData  = 32'd0;
        test_reset();
        test_straight();
        test_hold();
        test_redirect_wait();
        test_redirect_coincident();
        test_full_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
